// File: rtl/fifo_err_mgr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_err_mgr
// Brief    : FIFO error management. Registers the safety monitor's per-source
//            error bits and separates transient from permanent faults with an
//            OK / SUSPECT / FAULT state machine. Keeps sticky, first-error and
//            saturating error-cycle status. Status is cleared by a req/ack
//            handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_err_mgr #(
    parameter int NUM_SRC        = 4,
    parameter int CNT_WIDTH      = 8,
    parameter int PERSIST_CYCLES = 4,
    parameter int RECOVER_CYCLES = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic [NUM_SRC-1:0]   ErrIn,
    input  logic                 ClearReq,
    output logic                 ClearAck,
    output logic [1:0]           State,
    output logic                 Warn,
    output logic                 Alarm,
    output logic [NUM_SRC-1:0]   StickyErr,
    output logic [NUM_SRC-1:0]   FirstErr,
    output logic [CNT_WIDTH-1:0] ErrCount
);

    // Counter widths are sized so each counter can reach its own threshold.
    localparam int c_RUN_W   = $clog2(PERSIST_CYCLES + 1);
    localparam int c_CLEAN_W = $clog2(RECOVER_CYCLES + 1);

    localparam logic [c_RUN_W-1:0]   c_PERSIST = c_RUN_W'(PERSIST_CYCLES);
    localparam logic [c_CLEAN_W-1:0] c_RECOVER = c_CLEAN_W'(RECOVER_CYCLES);
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    logic [NUM_SRC-1:0]   r_err_q;
    logic                 w_any_q;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_RUN_W-1:0]   r_run;
    logic [c_RUN_W-1:0]   w_run_nxt;
    logic [c_RUN_W-1:0]   w_run_inc;
    logic [c_CLEAN_W-1:0] r_clean;
    logic [c_CLEAN_W-1:0] w_clean_nxt;
    logic [c_CLEAN_W-1:0] w_clean_inc;
    logic                 r_armed;
    logic                 r_ack;
    logic                 w_clear_take;
    logic                 r_warn;
    logic                 r_alarm;
    logic [NUM_SRC-1:0]   r_sticky;
    logic [NUM_SRC-1:0]   r_first;
    logic [CNT_WIDTH-1:0] r_count;

    assign w_any_q      = |r_err_q;
    assign w_run_inc    = r_run + c_RUN_W'(1);
    assign w_clean_inc  = r_clean + c_CLEAN_W'(1);
    // A clear is taken once per request: the ack cycle and the disarmed
    // period both block a held request from being taken again.
    assign w_clear_take = ClearReq & ~r_ack & r_armed;

    // Input register: all decisions are made on the registered error bits.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_err_q <= '0;
        end else begin
            r_err_q <= Enable ? ErrIn : '0;
        end
    end

    // Next-state and run/clean counter logic; a clear overrides this cycle's errors.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_clean_nxt = r_clean;
        if (w_clear_take) begin
            w_state_nxt = ST_OK;
            w_run_nxt   = '0;
            w_clean_nxt = '0;
        end else begin
            case (r_state)
                ST_OK: begin
                    if (w_any_q) begin
                        if (PERSIST_CYCLES == 1) begin
                            w_state_nxt = ST_FAULT;
                        end else begin
                            w_state_nxt = ST_SUSPECT;
                            w_run_nxt   = c_RUN_W'(1);
                            w_clean_nxt = '0;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (w_any_q) begin
                        w_run_nxt   = w_run_inc;
                        w_clean_nxt = '0;
                        if (w_run_inc == c_PERSIST) begin
                            w_state_nxt = ST_FAULT;
                        end
                    end else begin
                        w_run_nxt   = '0;
                        w_clean_nxt = w_clean_inc;
                        if (w_clean_inc == c_RECOVER) begin
                            w_state_nxt = ST_OK;
                        end
                    end
                end
                default: begin
                    // FAULT is absorbing; only a clear or reset leaves it.
                end
            endcase
        end
    end

    // State register with registered Warn/Alarm decodes of the next state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_OK;
            r_run   <= '0;
            r_clean <= '0;
            r_warn  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
            r_clean <= w_clean_nxt;
            r_warn  <= (w_state_nxt == ST_SUSPECT);
            r_alarm <= (w_state_nxt == ST_FAULT);
        end
    end

    // Clear handshake: one-cycle ack, re-armed once the request is seen low.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ack   <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_ack <= w_clear_take;
            if (w_clear_take) begin
                r_armed <= 1'b0;
            end else if (!ClearReq) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Status capture: sticky OR, first-error snapshot, saturating error count.
    always_ff @(posedge Clock) begin
        if (Reset || w_clear_take) begin
            r_sticky <= '0;
            r_first  <= '0;
            r_count  <= '0;
        end else if (w_any_q) begin
            r_sticky <= r_sticky | r_err_q;
            if (r_first == '0) begin
                r_first <= r_err_q;
            end
            if (r_count != c_CNT_MAX) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

    assign State     = r_state;
    assign Warn      = r_warn;
    assign Alarm     = r_alarm;
    assign ClearAck  = r_ack;
    assign StickyErr = r_sticky;
    assign FirstErr  = r_first;
    assign ErrCount  = r_count;

endmodule
`default_nettype wire

// File: doc/fifo_err_mgr.md
# fifo_err_mgr

Error-management stage downstream of the FIFO safety monitor. Takes the monitor's per-source error bits (flag, read-pointer, write-pointer and ECC mismatch), filters transients against permanent faults with a three-state FSM, and keeps sticky and first-error capture registers plus a saturating error-cycle count. Status is cleared through a req/ack handshake. The `Alarm` output is the FIFO subsystem's single registered fault indication to the system.

## Interface
- `NUM_SRC`, default 4: number of error sources. Bit 0 FlagError, 1 ReadError, 2 WriteError, 3 EccError.
- `CNT_WIDTH`, default 8: width of `ErrCount`.
- `PERSIST_CYCLES`, default 4: consecutive error cycles that declare a FAULT. Legal range ≥1.
- `RECOVER_CYCLES`, default 16: consecutive clean cycles in SUSPECT that return to OK. Legal range ≥1.

Ports:
- `Clock`  in  1: single clock; all logic on its rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `Enable`  in  1: monitoring enable. When low, `ErrIn` is ignored.
- `ErrIn`  in  NUM_SRC: raw per-source error bits from the safety monitor.
- `ClearReq`  in  1: level request to clear status and leave FAULT.
- `ClearAck`  out  1: one-cycle acknowledge of a clear.
- `State`  out  2: 0 = OK, 1 = SUSPECT, 2 = FAULT.
- `Warn`  out  1: high while `State` is SUSPECT.
- `Alarm`  out  1: high while `State` is FAULT.
- `StickyErr`  out  NUM_SRC: OR of every source seen since the last clear.
- `FirstErr`  out  NUM_SRC: source bits of the first error cycle since the last clear.
- `ErrCount`  out  CNT_WIDTH: saturating count of error cycles since the last clear.

## Operation
- **Input register:** `err_q <= Enable ? ErrIn : 0`. `any_q = |err_q`. All state and status logic uses `err_q`, never `ErrIn`.
- **Internal counters:** `run` counts consecutive `any_q` cycles; `clean` counts consecutive `!any_q` cycles. Each is sized to hold its threshold.
- **OK state:**
  - `any_q` and PERSIST_CYCLES==1 → FAULT.
  - Otherwise `any_q` → SUSPECT, with run=1 and clean=0.
- **SUSPECT state:**
  - `any_q`: run+1 and clean=0. If run+1 == PERSIST_CYCLES → FAULT.
  - `!any_q`: run=0 and clean+1. If clean+1 == RECOVER_CYCLES → OK.
- **FAULT state:** absorbing. Only a clear or `Reset` leaves it. Errors in FAULT still update the status registers.
- **Status registers** (every cycle unless a clear is taken):
  - `StickyErr |= err_q`.
  - `FirstErr <= err_q` when `FirstErr==0` and `any_q`.
  - `ErrCount` increments on `any_q` and saturates at all-ones.
- **Clear handshake:**
  - A clear is taken on the edge where `ClearReq=1`, `ClearAck=0` and `armed=1`.
  - That edge sets `State`=OK, zeroes run, clean, StickyErr, FirstErr and ErrCount, sets `ClearAck=1` for exactly one cycle, and sets `armed=0`.
  - `armed` is set again once `ClearReq` is sampled low. A held `ClearReq` therefore yields exactly one ack.
  - A clear is accepted in any state.
- **Simultaneous events:** a clear takes priority over `err_q` on the same edge; that cycle's `err_q` is discarded.
- **Enable low:** produces clean cycles. SUSPECT can recover; FAULT holds.

## Timing
- **Reset values:** `State`=0, `Warn`=0, `Alarm`=0, `ClearAck`=0, `StickyErr`=0, `FirstErr`=0, `ErrCount`=0. Internal: `err_q`=0, run=0, clean=0, `armed`=1.
- **Error latency:** `ErrIn` sampled at edge k reaches `err_q` at k; state and status update at edge k+1. All outputs are registered, so the latency from `ErrIn` to output is 2 edges.
- **Clear latency:** `ClearReq` sampled at edge k gives `ClearAck` and cleared outputs after edge k.
- **FAULT timing:** with N consecutive error input cycles starting at edge k, FAULT is visible after edge k+N (N = PERSIST_CYCLES).
- **Reset mid-operation:** `Reset` overrides everything on its edge, including a pending clear.

## Test plan
1. **Reset:** assert `Reset` 3 cycles with `ErrIn`=1111 → all outputs 0, `State`=0.
2. **Transient:** one-cycle `ErrIn`=0010 → after 2 edges `State`=1, `Warn`=1, `StickyErr`=0010, `FirstErr`=0010, `ErrCount`=1. Then 16 clean cycles → `State`=0; sticky bits retained.
3. **Persistent fault:** `ErrIn`=0100 held 4 cycles then 0001 → `Alarm`=1 four edges after the first `err_q`. `ErrCount`=5, `StickyErr`=0101, `FirstErr`=0100; `State` stays 2 for 100 clean cycles.
4. **Clear in FAULT:** hold `ClearReq` 5 cycles with `ErrIn`=1000 continuous → one `ClearAck` pulse. Outputs 0 on the ack cycle, then SUSPECT and FAULT again as errors continue. A second ack comes only after `ClearReq` drops and rises again.
5. **Non-persistent pattern:** alternating `ErrIn`=0001/0000 for 50 cycles → `State` never 2 and `ErrCount`=25. Then 300 error cycles → `ErrCount`=255 (saturated).
6. **Disabled input:** `Enable`=0 with `ErrIn`=1111 for 20 cycles → no output changes. `Enable`=0 while in SUSPECT → return to OK after 16 cycles.
